// File: rtl/lbus_pkg.sv
// Shared definitions for the local-bus read responder: read-map addresses,
// the version byte and the bus FSM state encoding.
package lbus_pkg;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_POS0    = 4'd1;
  localparam logic [3:0] ADDR_POS1    = 4'd2;
  localparam logic [3:0] ADDR_POS2    = 4'd3;
  localparam logic [3:0] ADDR_POS3    = 4'd4;
  localparam logic [3:0] ADDR_LIMIT   = 4'd5;
  localparam logic [3:0] ADDR_ID      = 4'd6;
  localparam logic [3:0] ADDR_VERSION = 4'd7;

  localparam logic [7:0] VERSION_BYTE = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRIVE,
    HOLD
  } lbus_state_e;

endpackage

// File: rtl/lbus_readback_if.sv
// Local-bus read-side signals: host strobes and address in, pad data,
// output enable and active-low ready back out.
interface lbus_readback_if;
  logic       ADS;
  logic       LRD;
  logic [7:0] LAD;
  logic [7:0] LAD_OUT;
  logic       LAD_OE;
  logic       LRDY;

  modport master (output ADS, LRD, LAD, input  LAD_OUT, LAD_OE, LRDY);
  modport slave  (input  ADS, LRD, LAD, output LAD_OUT, LAD_OE, LRDY);
endinterface

// File: rtl/lbus_readback_step_pos_counter.sv
// Step position counter: counts ST_CLK rising edges up or down by ST_DIR,
// wraps modulo 2^POS_W, and is forced to zero while i_clear is high.
module step_pos_counter #(
  parameter int POS_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_st_clk,
  input  logic             i_st_dir,
  input  logic             i_clear,
  output logic [POS_W-1:0] o_pos
);

  logic             r_st_clk_d;
  logic [POS_W-1:0] r_pos;
  logic             w_rise;

  assign w_rise = i_st_clk & ~r_st_clk_d;
  assign o_pos  = r_pos;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st_clk_d <= 1'b0;
      r_pos      <= '0;
    end else begin
      r_st_clk_d <= i_st_clk;
      // Clear dominates a coincident step so a disabled axis reads zero.
      if (i_clear)
        r_pos <= '0;
      else if (w_rise)
        r_pos <= i_st_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
    end
  end

endmodule

// File: rtl/lbus_readback.sv
// Local-bus read responder: address latch, wait-state FSM, read mux, sticky
// limit flags. Define LBUS_POS_SNAPSHOT_EN for coherent multi-byte position reads.
module lbus_readback
  import lbus_pkg::*;
#(
  parameter int         WAIT_STATES = 1,
  parameter int         POS_W       = 32,
  parameter logic [7:0] ID_BYTE     = 8'h24
) (
  input  logic            LClk,
  input  logic            Reset,
  lbus_readback_if.slave  lb,
  input  logic            ST_CLK,
  input  logic            ST_DIR,
  input  logic            ST_ENB,
  input  logic            ST_DIS,
  input  logic            SP_DIS,
  input  logic            SP_DIR,
  input  logic            SP_BRK,
  input  logic [1:0]      LIMIT_N
);

  lbus_state_e      r_state, w_next;
  logic [3:0]       r_wait_cnt, w_wait_next;
  logic [3:0]       r_addr, w_addr;
  logic [7:0]       r_lad_out, w_rd_data;
  logic             r_lad_oe, r_lrdy;
  logic [1:0]       r_lim_sync1, r_lim_sync2, r_lim, w_lim_clr;
  logic [POS_W-1:0] w_pos, w_pos_rd;
  logic [3:0]       w_lad_hi_unused;

  // Only A[3:0] is decoded; the upper address bits are intentionally dropped.
  assign w_lad_hi_unused = lb.LAD[7:4];

  step_pos_counter #(.POS_W(POS_W)) u_pos (
    .i_clk    (LClk),
    .i_rst    (Reset),
    .i_st_clk (ST_CLK),
    .i_st_dir (ST_DIR),
    .i_clear  (~ST_ENB & ST_DIS),
    .o_pos    (w_pos)
  );

  // A read strobe coinciding with ADS must decode the address being latched.
  assign w_addr = (r_state == IDLE && !lb.ADS) ? lb.LAD[3:0] : r_addr;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    case (r_state)
      IDLE: if (!lb.LRD) begin
        if (WAIT_STATES == 0) begin
          w_next = DRIVE;
        end else begin
          w_next      = WAIT;
          w_wait_next = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (lb.LRD)                 w_next = IDLE;
        else if (r_wait_cnt == 4'd0) w_next = DRIVE;
        else                         w_wait_next = r_wait_cnt - 4'd1;
      end
      DRIVE:   w_next = HOLD;
      HOLD:    if (lb.LRD) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef LBUS_POS_SNAPSHOT_EN
  logic [POS_W-1:0] r_snap;

  always_ff @(posedge LClk) begin
    if (Reset)
      r_snap <= '0;
    else if (w_next == DRIVE && w_addr == ADDR_POS0)
      r_snap <= w_pos;
  end

  assign w_pos_rd = {r_snap[POS_W-1:8], w_pos[7:0]};
`else
  assign w_pos_rd = w_pos;
`endif

  always_comb begin
    w_rd_data = 8'h00;
    case (w_addr)
      ADDR_STATUS:  w_rd_data = {r_lim, SP_BRK, SP_DIR, SP_DIS, ST_ENB, ST_DIR, ST_DIS};
      ADDR_POS0:    w_rd_data = w_pos_rd[7:0];
      ADDR_POS1:    w_rd_data = w_pos_rd[15:8];
      ADDR_POS2:    w_rd_data = w_pos_rd[23:16];
      ADDR_POS3:    w_rd_data = w_pos_rd[31:24];
      ADDR_LIMIT:   w_rd_data = {6'b0, r_lim};
      ADDR_ID:      w_rd_data = ID_BYTE;
      ADDR_VERSION: w_rd_data = VERSION_BYTE;
      default:      w_rd_data = 8'h00;
    endcase
  end

  // Clear-on-read fires on the same edge that loads the returned data.
  assign w_lim_clr = (w_next == DRIVE && w_addr == ADDR_LIMIT) ? 2'b11 : 2'b00;

  always_ff @(posedge LClk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 4'd0;
      r_addr      <= 4'd0;
      r_lad_out   <= 8'h00;
      r_lad_oe    <= 1'b0;
      r_lrdy      <= 1'b1;
      r_lim_sync1 <= 2'b11;
      r_lim_sync2 <= 2'b11;
      r_lim       <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (r_state == IDLE && !lb.ADS)
        r_addr <= lb.LAD[3:0];
      r_lad_oe <= (w_next == DRIVE) || (w_next == HOLD);
      r_lrdy   <= (w_next != DRIVE);
      if (w_next == DRIVE)
        r_lad_out <= w_rd_data;
      r_lim_sync1 <= LIMIT_N;
      r_lim_sync2 <= r_lim_sync1;
      r_lim       <= (r_lim & ~w_lim_clr) | ~r_lim_sync2;
    end
  end

  assign lb.LAD_OUT = r_lad_out;
  assign lb.LAD_OE  = r_lad_oe;
  assign lb.LRDY    = r_lrdy;

endmodule

// File: tb/tb_lbus_readback.sv
// Self-checking bench for lbus_readback: a timeline/register model predicts
// every bus cycle of the main instance; a second instance covers WAIT_STATES=3.
module tb_lbus_readback;

  localparam int WS = 1;

  logic       LClk = 1'b0;
  logic       Reset = 1'b1;
  logic       st_clk = 1'b0, st_dir = 1'b0, st_enb = 1'b1, st_dis = 1'b0;
  logic       sp_dis = 1'b1, sp_dir = 1'b0, sp_brk = 1'b1;
  logic [1:0] limit_n = 2'b11;

  lbus_readback_if bus ();
  lbus_readback_if bus3 ();

  lbus_readback #(.WAIT_STATES(WS), .POS_W(32), .ID_BYTE(8'h24)) dut (
    .LClk(LClk), .Reset(Reset), .lb(bus),
    .ST_CLK(st_clk), .ST_DIR(st_dir), .ST_ENB(st_enb), .ST_DIS(st_dis),
    .SP_DIS(sp_dis), .SP_DIR(sp_dir), .SP_BRK(sp_brk), .LIMIT_N(limit_n)
  );

  lbus_readback #(.WAIT_STATES(3), .POS_W(32), .ID_BYTE(8'h24)) dut3 (
    .LClk(LClk), .Reset(Reset), .lb(bus3),
    .ST_CLK(st_clk), .ST_DIR(st_dir), .ST_ENB(st_enb), .ST_DIS(st_dis),
    .SP_DIS(sp_dis), .SP_DIR(sp_dir), .SP_BRK(sp_brk), .LIMIT_N(limit_n)
  );

  always #5 LClk = ~LClk;

  int e = 0;
  always @(posedge LClk) e <= e + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: register contents as plain values, bus timing as cycle numbers.
  logic [31:0] m_pos = 32'd0;
  logic [31:0] m_snap = 32'd0;
  logic [1:0]  m_lim = 2'b00;
  logic [1:0]  lim_held = 2'b00;
  int          drv_cyc = -10;
  int          rel_cyc = -10;
  logic [7:0]  exp_data = 8'h00;
  bit          chk_en = 1'b0;

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [31:0] p;
    p = m_pos;
`ifdef LBUS_POS_SNAPSHOT_EN
    if (a >= 4'd2 && a <= 4'd4) p = m_snap;
`endif
    case (a)
      4'd0:    return {m_lim, sp_brk, sp_dir, sp_dis, st_enb, st_dir, st_dis};
      4'd1:    return p[7:0];
      4'd2:    return p[15:8];
      4'd3:    return p[23:16];
      4'd4:    return p[31:24];
      4'd5:    return {6'b0, m_lim};
      4'd6:    return 8'h24;
      4'd7:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_side_effect(input logic [3:0] a);
    if (a == 4'd5) m_lim = lim_held;
    if (a == 4'd1) m_snap = m_pos;
  endtask

  // Compare process: ready pulses only in the drive cycle, enable spans drive..release.
  always @(negedge LClk) begin
    if (chk_en) begin
      check("LRDY", {7'b0, bus.LRDY}, {7'b0, !(e == drv_cyc)});
      check("LAD_OE", {7'b0, bus.LAD_OE}, {7'b0, (e >= drv_cyc && e < rel_cyc)});
      if (e >= drv_cyc && e < rel_cyc)
        check("LAD_OUT", bus.LAD_OUT, exp_data);
    end
  end

  task automatic do_read(input logic [3:0] addr, output logic [7:0] got);
    @(posedge LClk); #1;
    bus.ADS = 1'b0;
    bus.LAD = {4'h0, addr};
    @(posedge LClk); #1;
    bus.ADS = 1'b1;
    bus.LRD = 1'b0;
    exp_data = model_read(addr);
    model_side_effect(addr);
    rel_cyc  = 1 << 30;
    drv_cyc  = e + 2 + WS;
    while (e < drv_cyc) begin
      @(posedge LClk); #1;
    end
    @(negedge LClk);
    got = bus.LAD_OUT;
    @(posedge LClk); #1;
    bus.LRD = 1'b1;
    rel_cyc = e + 1;
    repeat (2) begin
      @(posedge LClk); #1;
    end
  endtask

  task automatic step(input logic dir, input int n);
    st_dir = dir;
    for (int i = 0; i < n; i++) begin
      @(posedge LClk); #1 st_clk = 1'b1;
      @(posedge LClk); #1 st_clk = 1'b0;
      m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
    end
    @(posedge LClk); #1;
  endtask

  logic [7:0] d;
  int         lat;

  initial begin
    bus.ADS = 1'b1;  bus.LRD = 1'b1;  bus.LAD = 8'h00;
    bus3.ADS = 1'b1; bus3.LRD = 1'b1; bus3.LAD = 8'h00;

    repeat (3) @(posedge LClk);
    @(negedge LClk);
    check("rst_oe", {7'b0, bus.LAD_OE}, 8'h00);
    check("rst_rdy", {7'b0, bus.LRDY}, 8'h01);
    check("rst_out", bus.LAD_OUT, 8'h00);
    check("rst3_oe", {7'b0, bus3.LAD_OE}, 8'h00);
    @(posedge LClk); #1;
    Reset = 1'b0;
    @(posedge LClk); #1;
    chk_en = 1'b1;

    do_read(4'd6, d); check("id_byte", d, 8'h24);
    do_read(4'd0, d); check("status_rst", d, 8'h2C);
    do_read(4'd7, d); check("version", d, 8'h01);
    do_read(4'd9, d); check("unmapped", d, 8'h00);

    step(1'b1, 5);
    step(1'b0, 7);
    do_read(4'd1, d); check("pos_b0_wrap", d, 8'hFE);
    do_read(4'd2, d); check("pos_b1_wrap", d, 8'hFF);
    do_read(4'd3, d); check("pos_b2_wrap", d, 8'hFF);
    do_read(4'd4, d); check("pos_b3_wrap", d, 8'hFF);

    // ST_ENB low with ST_DIS high zeroes the count.
    st_enb = 1'b0; st_dis = 1'b1;
    repeat (2) @(posedge LClk); #1;
    st_enb = 1'b1; st_dis = 1'b0;
    m_pos = 32'd0;
    do_read(4'd1, d); check("pos_cleared", d, 8'h00);

    step(1'b1, 255);
    do_read(4'd1, d); check("pos_ff", d, 8'hFF);
    step(1'b1, 1);
`ifdef LBUS_POS_SNAPSHOT_EN
    do_read(4'd2, d); check("snap_b1", d, 8'h00);
`else
    do_read(4'd2, d); check("live_b1", d, 8'h01);
`endif

    // One-cycle limit pulse becomes a sticky flag.
    @(posedge LClk); #1 limit_n = 2'b10;
    @(posedge LClk); #1 limit_n = 2'b11;
    repeat (4) @(posedge LClk); #1;
    m_lim[0] = 1'b1;
    do_read(4'd0, d); check("status_lim0", {7'b0, d[6]}, 8'h01);
    do_read(4'd5, d); check("lim_read", d, 8'h01);
    do_read(4'd5, d); check("lim_cleared", d, 8'h00);

    // WAIT_STATES=3 instance: abort in WAIT has no effect, then full read latency.
    chk_en = 1'b0;
    @(posedge LClk); #1 bus3.ADS = 1'b0; bus3.LAD = 8'h05;
    @(posedge LClk); #1 bus3.ADS = 1'b1; bus3.LRD = 1'b0;
    @(posedge LClk); #1;
    @(posedge LClk); #1 bus3.LRD = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge LClk);
      check("abort_rdy", {7'b0, bus3.LRDY}, 8'h01);
      check("abort_oe", {7'b0, bus3.LAD_OE}, 8'h00);
    end
    @(posedge LClk); #1 bus3.ADS = 1'b0; bus3.LAD = 8'h05;
    @(posedge LClk); #1 bus3.ADS = 1'b1; bus3.LRD = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge LClk);
      if (!bus3.LRDY) begin
        lat = i;
        d   = bus3.LAD_OUT;
      end
    end
    check("ws3_latency", 8'(lat), 8'd6);
    check("ws3_lim_kept", d, 8'h01);
    @(posedge LClk); #1 bus3.LRD = 1'b1;
    repeat (2) @(posedge LClk); #1;
    chk_en = 1'b1;

    // Limit held low through a clear: set wins, flag stays.
    lim_held = 2'b01; limit_n = 2'b10;
    repeat (4) @(posedge LClk); #1;
    m_lim = m_lim | lim_held;
    do_read(4'd5, d); check("held_read1", d, 8'h01);
    do_read(4'd5, d); check("held_read2", d, 8'h01);
    lim_held = 2'b00; limit_n = 2'b11;
    repeat (4) @(posedge LClk); #1;
    do_read(4'd5, d); check("rel_read1", d, 8'h01);
    do_read(4'd5, d); check("rel_read2", d, 8'h00);

    // Reset while the main instance sits in HOLD.
    chk_en = 1'b0;
    @(posedge LClk); #1 bus.ADS = 1'b0; bus.LAD = 8'h02;
    @(posedge LClk); #1 bus.ADS = 1'b1; bus.LRD = 1'b0;
    repeat (WS + 3) @(posedge LClk); #1;
    check("hold_oe", {7'b0, bus.LAD_OE}, 8'h01);
    Reset = 1'b1;
    @(posedge LClk); #1;
    check("mid_rst_oe", {7'b0, bus.LAD_OE}, 8'h00);
    check("mid_rst_rdy", {7'b0, bus.LRDY}, 8'h01);
    check("mid_rst_out", bus.LAD_OUT, 8'h00);
    Reset = 1'b0; bus.LRD = 1'b1;
    m_pos = 32'd0; m_snap = 32'd0; m_lim = 2'b00;
    drv_cyc = -10; rel_cyc = -10;
    repeat (2) @(posedge LClk); #1;
    chk_en = 1'b1;
    do_read(4'd2, d); check("post_rst_b1", d, 8'h00);
    do_read(4'd1, d); check("post_rst_b0", d, 8'h00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
